// File: rtl/cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups.
// Define CLA_PIPE_SAT_EN to saturate the sum to the signed limit on overflow.
module cla_pipe #(
  parameter int WIDTH = 16,
  parameter int GPS   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NG  = WIDTH / 4;
  localparam int LAT = (NG + GPS - 1) / GPS;

  function automatic logic [4:0] cla4(
    input logic [3:0] x,
    input logic [3:0] y,
    input logic       ci
  );
    logic [3:0] p, g;
    logic [4:0] c;
    p    = x ^ y;
    g    = x & y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | ((&p) & ci);
    return {c[4], p ^ c[3:0]};
  endfunction

  logic             stall;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign b_eff    = sub ? ~b : b;
  assign c0       = sub | cin;

  for (genvar k = 0; k < LAT; k++) begin : g_stg
    localparam int LO  = 4 * k * GPS;
    localparam int HI  = (4 * (k + 1) * GPS < WIDTH) ?
                         4 * (k + 1) * GPS : WIDTH;
    localparam int UW  = WIDTH - LO;
    localparam int NGS = (HI - LO) / 4;

    logic [UW-1:0]    a_in, b_in;
    logic             c_in, v_in;
    logic [HI-LO-1:0] s_new;
    logic [HI-1:0]    s_d, s_w, s_q;
    logic             c_d, c_q, v_q;
    logic [4:0]       r;

    // Unconsumed upper operand bits arrive already aligned to bit 0.
    if (k == 0) begin : g_in
      assign a_in = a;
      assign b_in = b_eff;
      assign c_in = c0;
      assign v_in = in_valid;
      assign s_d  = s_new;
    end else begin : g_in
      assign a_in = g_stg[k-1].g_fwd.a_q;
      assign b_in = g_stg[k-1].g_fwd.b_q;
      assign c_in = g_stg[k-1].c_q;
      assign v_in = g_stg[k-1].v_q;
      assign s_d  = {s_new, g_stg[k-1].s_q};
    end

    always_comb begin
      r     = '0;
      c_d   = c_in;
      s_new = '0;
      for (int g = 0; g < NGS; g++) begin
        r                = cla4(a_in[4*g +: 4], b_in[4*g +: 4], c_d);
        s_new[4*g +: 4]  = r[3:0];
        c_d              = r[4];
      end
    end

    if (k == LAT - 1) begin : g_last
      logic ovf_d, ovf_q;
      assign ovf_d = (a_in[UW-1] == b_in[UW-1]) &
                     (s_d[WIDTH-1] != a_in[UW-1]);
`ifdef CLA_PIPE_SAT_EN
      assign s_w = ovf_d ?
                   {a_in[UW-1], {(WIDTH-1){~a_in[UW-1]}}} : s_d;
`else
      assign s_w = s_d;
`endif
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (!stall) begin
          ovf_q <= ovf_d;
        end
      end
    end else begin : g_fwd
      logic [WIDTH-HI-1:0] a_q, b_q;
      assign s_w = s_d;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (!stall) begin
          a_q <= a_in[UW-1:HI-LO];
          b_q <= b_in[UW-1:HI-LO];
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (!stall) begin
        v_q <= v_in;
        c_q <= c_d;
        s_q <= s_w;
      end
    end
  end

  assign out_valid = g_stg[LAT-1].v_q;
  assign sum       = g_stg[LAT-1].s_q;
  assign cout      = g_stg[LAT-1].c_q;
  assign ovf       = g_stg[LAT-1].g_last.ovf_q;

endmodule

// File: tb/tb_cla_pipe.sv
// Directed bench for cla_pipe at WIDTH=16 with GPS=1, 2 and 4.
// Expected sums follow CLA_PIPE_SAT_EN when it is defined.
module tb_cla_pipe;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sraw;
    logic [15:0] ssat;
    logic        co;
    logic        ov;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready, cin, sub;
  logic [15:0] a, b;
  logic [2:0]  irdy, ovld, cout_w, ovf_w;
  logic [15:0] sum_w [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cla_pipe #(.WIDTH(16), .GPS(1)) u_g1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[0]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(ovld[0]),
    .out_ready(out_ready), .sum(sum_w[0]), .cout(cout_w[0]),
    .ovf(ovf_w[0]));

  cla_pipe #(.WIDTH(16), .GPS(2)) u_g2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[1]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(ovld[1]),
    .out_ready(out_ready), .sum(sum_w[1]), .cout(cout_w[1]),
    .ovf(ovf_w[1]));

  cla_pipe #(.WIDTH(16), .GPS(4)) u_g4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[2]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(ovld[2]),
    .out_ready(out_ready), .sum(sum_w[2]), .cout(cout_w[2]),
    .ovf(ovf_w[2]));

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int          lat [3];
    logic [15:0] s [3];
    logic        c [3];
    logic        o [3];
    int          explat [3];
    logic [15:0] es;
    explat = '{4, 2, 1};
`ifdef CLA_PIPE_SAT_EN
    es = v.ssat;
`else
    es = v.sraw;
`endif
    for (int d = 0; d < 3; d++) begin
      lat[d] = 0; s[d] = '0; c[d] = 1'b0; o[d] = 1'b0;
    end
    a = v.a; b = v.b; cin = v.cin; sub = v.sub;
    in_valid = 1'b1;
    for (int cy = 1; cy <= 8; cy++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int d = 0; d < 3; d++) begin
        if (ovld[d] && lat[d] == 0) begin
          lat[d] = cy; s[d] = sum_w[d];
          c[d] = cout_w[d]; o[d] = ovf_w[d];
        end
      end
    end
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s/d%0d lat", nm, d), lat[d], explat[d]);
      chk($sformatf("%s/d%0d sum", nm, d), s[d], es);
      chk($sformatf("%s/d%0d cout", nm, d), c[d], v.co);
      chk($sformatf("%s/d%0d ovf", nm, d), o[d], v.ov);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        vt [10];
    vec_t        vr;
    logic [15:0] sa [6], sb [6], se [6];
    int          sent, got, stall_left, extra;
    bit          stall_seen, fire_in;

    vt[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 16'h0100, 1'b0, 1'b0};
    vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vt[2] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 16'hFFFE, 1'b0, 1'b0};
    vt[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 16'h8000, 1'b1, 1'b1};
    vt[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 16'h7FFF, 1'b0, 1'b1};
    vt[5] = '{16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 16'h8000, 1'b1, 1'b1};
    vt[6] = '{16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 16'h2346, 1'b0, 1'b0};
    vt[7] = '{16'h1000, 16'h1000, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vt[8] = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 16'h1000, 1'b0, 1'b0};
    vt[9] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0};

    for (int i = 0; i < 6; i++) begin
      sa[i] = 16'h0F80 + 16'h0111 * i[15:0];
      sb[i] = 16'h0080 + i[15:0];
      se[i] = sa[i] + sb[i];
    end

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #12;
    chk("reset out_valid", ovld, 3'b000);
    chk("reset sum", sum_w[0], 16'h0000);
    chk("reset cout", cout_w, 3'b000);
    chk("reset ovf", ovf_w, 3'b000);
    chk("reset in_ready", irdy, 3'b111);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post-reset in_ready", irdy, 3'b111);
    chk("post-reset out_valid", ovld, 3'b000);

    for (int i = 0; i < 10; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    sent = 0; got = 0; stall_left = 0; stall_seen = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      in_valid = (sent < 6);
      if (sent < 6) begin
        a = sa[sent]; b = sb[sent]; cin = 1'b0; sub = 1'b0;
      end
      if (ovld[0] && !stall_seen) begin
        stall_seen = 1'b1;
        stall_left = 3;
      end
      out_ready = (stall_left == 0);
      #1;
      if (stall_left > 0) begin
        chk("stream stall in_ready", irdy[0], 1'b0);
        chk("stream stall valid", ovld[0], 1'b1);
        chk("stream stall sum", sum_w[0], se[got]);
      end
      fire_in = in_valid && irdy[0];
      if (ovld[0] && out_ready) begin
        chk($sformatf("stream res%0d", got), sum_w[0], se[got]);
        got++;
      end
      @(posedge clk); #1;
      if (fire_in) sent++;
      if (stall_left > 0) stall_left--;
    end
    chk("stream results", got, 6);
    in_valid = 1'b0; out_ready = 1'b1;
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ovld[0]) extra++;
    end
    chk("stream no duplicate", extra, 0);

    for (int i = 0; i < 3; i++) begin
      a = 16'h0101 * 16'(i + 1); b = 16'h0202;
      cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("inflight out_valid", ovld[0], 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async rst out_valid", ovld, 3'b000);
    chk("async rst sum", sum_w[0], 16'h0000);
    chk("async rst in_ready", irdy, 3'b111);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ovld != 3'b000) extra++;
    end
    chk("no stale result", extra, 0);
    vr = '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 16'h2345, 1'b0, 1'b0};
    run_vec(vr, "after-rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
